scram: RTL and testbench



---
 rtl/scram_if.sv | 35 +++
 rtl/scram.sv | 84 ++++++++
 tb/tb_scram.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/scram_if.sv
// scram_if: bundles the control, data and status signals of the scram block.
// Ports (signals): CE, Scr_En, Seed_Ld, Seed[PP-1:0], Dat_i[DW-1:0] toward the block;
//                  Dat_o[DW-1:0], Vld_o from the block; Prbs_Md only with SCRAM_PRBS_EN.
// master modport is the driving side (framer / bench), slave modport is the scrambler.
interface scram_if #(
   parameter int DW = 62,
   parameter int PP = 58
);
   logic          CE;
   logic          Scr_En;
   logic          Seed_Ld;
   logic [PP-1:0] Seed;
   logic [DW-1:0] Dat_i;
   logic [DW-1:0] Dat_o;
   logic          Vld_o;
`ifdef SCRAM_PRBS_EN
   logic          Prbs_Md;
`endif

   modport master (
      output CE, Scr_En, Seed_Ld, Seed, Dat_i,
`ifdef SCRAM_PRBS_EN
      output Prbs_Md,
`endif
      input  Dat_o, Vld_o
   );

   modport slave (
      input  CE, Scr_En, Seed_Ld, Seed, Dat_i,
`ifdef SCRAM_PRBS_EN
      input  Prbs_Md,
`endif
      output Dat_o, Vld_o
   );
endinterface

// File: rtl/scram.sv
// scram: parallel self-synchronizing (multiplicative) scrambler, DW bits per word, MSB first.
// Ports: Ck clock, Rs async active-high reset, bus (scram_if.slave): CE, Scr_En, Seed_Ld,
//        Seed, Dat_i in; Dat_o, Vld_o out, both registered (1 enabled clock latency).
// Optional macro SCRAM_PRBS_EN adds bus.Prbs_Md, which forces the data to zero (PRBS output).
module scram #(
   parameter int              DW   = 62,
   parameter int              PP   = 58,
   parameter logic [PP-1:0]   DI   = 58'h3ffffffffffffff,
   parameter logic [PP:0]     POLY = 59'h400008000000001
) (
   input logic    Ck,
   input logic    Rs,
   scram_if.slave bus
);

   // Scrambled history: state[0] is the most recent transmitted bit.
   logic [PP-1:0] state;
   logic [DW-1:0] dat_q;
   logic          vld_q;

   logic [PP-1:0] hist;
   logic [DW-1:0] din;
   logic [DW-1:0] word_nxt;
   logic [PP-1:0] state_nxt;

   // Ripple chain over one word. The working vector is ordered newest-first:
   // v[0] = word bit 0 (newest), v[DW-1] = oldest word bit, v[DW+j-1] = hist[j-1].
   // So the bit j positions before word bit k is always v[k+j], whether it lies
   // inside the word or in the history. Walking k from DW-1 down to 0 means every
   // tap is already final when it is read. The post-word history is simply the
   // newest PP bits v[PP-1:0], which covers both DW >= PP and DW < PP.
   // Returns {scrambled word, post-word state}.
   function automatic logic [DW+PP-1:0] scramble(input logic [PP-1:0] h,
                                                 input logic [DW-1:0] d);
      logic [DW+PP-1:0] v;
      logic             b;
      v = {h, {DW{1'b0}}};
      for (int k = DW - 1; k >= 0; k--) begin
         b = d[k];
         // Taps above PP are outside the declared POLY width and cannot appear.
         for (int j = 1; j <= PP; j++) begin
            if (POLY[j]) begin
               b = b ^ v[k + j];
            end
         end
         v[k] = b;
      end
      return {v[DW-1:0], v[PP-1:0]};
   endfunction

   // A seed loaded together with a word becomes that word's history.
   assign hist = bus.Seed_Ld ? bus.Seed : state;

`ifdef SCRAM_PRBS_EN
   assign din = bus.Prbs_Md ? '0 : bus.Dat_i;
`else
   assign din = bus.Dat_i;
`endif

   assign {word_nxt, state_nxt} = scramble(hist, din);

   always_ff @(posedge Ck or posedge Rs) begin
      if (Rs) begin
         state <= DI;
         dat_q <= '0;
         vld_q <= 1'b0;
      end else if (bus.CE) begin
         if (bus.Scr_En) begin
            dat_q <= word_nxt;
            vld_q <= 1'b1;
            state <= state_nxt;
         end else begin
            vld_q <= 1'b0;
            if (bus.Seed_Ld) begin
               state <= bus.Seed;
            end
         end
      end
   end

   assign bus.Dat_o = dat_q;
   assign bus.Vld_o = vld_q;

endmodule

// File: tb/tb_scram.sv
// tb_scram: randomized self-checking bench for scram against a serial bit-queue model.
// Ports: none; drives Ck/Rs and a scram_if instance, checks Dat_o/Vld_o each cycle.
// Loopback is checked with a serial descrambler model fed from Dat_o.
module tb_scram;
   localparam int              DW   = 62;
   localparam int              PP   = 58;
   localparam logic [PP-1:0]   DI   = 58'h3ffffffffffffff;
   localparam logic [PP:0]     POLY = 59'h400008000000001;

   logic Ck = 1'b0;
   logic Rs = 1'b0;
   scram_if #(.DW(DW), .PP(PP)) bus ();

   scram #(.DW(DW), .PP(PP), .DI(DI), .POLY(POLY)) dut (
      .Ck  (Ck),
      .Rs  (Rs),
      .bus (bus)
   );

   always #5 Ck = ~Ck;

   int n_cmp = 0;
   int n_err = 0;

   int taps[$];
   bit mhist[$];   // scrambler model history, [0] newest
   bit dhist[$];   // descrambler model history, [0] newest received bit
   logic [DW-1:0] exp_dat;
   logic          exp_vld;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mdl_load(input logic [PP-1:0] s);
      mhist.delete();
      for (int i = 0; i < PP; i++) mhist.push_back(s[i]);
   endtask

   // Serial scrambler: s[n] = d[n] ^ XOR of s[n-j] over taps j, oldest bit first.
   task automatic mdl_scr(input logic [DW-1:0] d, output logic [DW-1:0] s);
      bit b;
      for (int k = DW - 1; k >= 0; k--) begin
         b = d[k];
         foreach (taps[t]) b ^= mhist[taps[t] - 1];
         mhist.push_front(b);
         void'(mhist.pop_back());
         s[k] = b;
      end
   endtask

   // Serial descrambler: d[n] = r[n] ^ XOR of r[n-j] over taps j.
   task automatic mdl_dscr(input logic [DW-1:0] r, output logic [DW-1:0] d);
      bit b;
      for (int k = DW - 1; k >= 0; k--) begin
         b = r[k];
         foreach (taps[t]) b ^= dhist[taps[t] - 1];
         dhist.push_front(r[k]);
         void'(dhist.pop_back());
         d[k] = b;
      end
   endtask

   task automatic cycle(input string tag, input bit ce, input bit en, input bit ld,
                        input logic [PP-1:0] seed, input logic [DW-1:0] din, input bit prbs);
      logic [DW-1:0] w;
      bus.CE      = ce;
      bus.Scr_En  = en;
      bus.Seed_Ld = ld;
      bus.Seed    = seed;
      bus.Dat_i   = din;
`ifdef SCRAM_PRBS_EN
      bus.Prbs_Md = prbs;
`endif
      @(posedge Ck);
      #1;
      if (ce) begin
         if (ld) mdl_load(seed);
         if (en) begin
            mdl_scr(prbs ? '0 : din, w);
            exp_dat = w;
            exp_vld = 1'b1;
         end else begin
            exp_vld = 1'b0;
         end
      end
      chk({tag, "/dat"}, 64'(bus.Dat_o), 64'(exp_dat));
      chk({tag, "/vld"}, 64'(bus.Vld_o), 64'(exp_vld));
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   initial begin
      logic [DW-1:0] w;
      logic [DW-1:0] rec;
      logic [PP-1:0] sd;
      int words;
      bit ce, en;

      for (int j = 1; j <= PP; j++) if (POLY[j]) taps.push_back(j);
      for (int i = 0; i < PP; i++) dhist.push_back(1'b0);
      mdl_load(DI);
      exp_dat = '0;
      exp_vld = 1'b0;

      bus.CE = 1'b0; bus.Scr_En = 1'b0; bus.Seed_Ld = 1'b0;
      bus.Seed = '0; bus.Dat_i = '0;
`ifdef SCRAM_PRBS_EN
      bus.Prbs_Md = 1'b0;
`endif

      // Reset state
      #2 Rs = 1'b1;
      #1;
      chk("rst/dat", 64'(bus.Dat_o), 64'h0);
      chk("rst/vld", 64'(bus.Vld_o), 64'h0);
      @(posedge Ck); @(posedge Ck); #1;
      Rs = 1'b0;

      // First word after reset with zero data
      cycle("first", 1, 1, 0, '0, '0, 0);
      chk("first/vec", 64'(bus.Dat_o), 64'h00000000007FFFF0);

      // A few random words, then CE hold with changing data
      for (int i = 0; i < 4; i++) cycle("pre", 1, 1, 0, '0, rnd_word(), 0);
      for (int i = 0; i < 5; i++) cycle("hold", 0, $urandom_range(0, 1), 0, '0, rnd_word(), 0);
      for (int i = 0; i < 3; i++) cycle("resume", 1, 1, 0, '0, rnd_word(), 0);

      // Enable gap: Vld_o drops, Dat_o holds
      cycle("gap", 1, 0, 0, '0, rnd_word(), 0);
      chk("gap/vld0", 64'(bus.Vld_o), 64'h0);

      // Seed 0 with zero data: all-zero stream persists
      cycle("seed0", 1, 1, 1, '0, '0, 0);
      chk("seed0/zero", 64'(bus.Dat_o), 64'h0);
      for (int i = 0; i < 4; i++) begin
         cycle("zero", 1, 1, 0, '0, '0, 0);
         chk("zero/const", 64'(bus.Dat_o), 64'h0);
      end

      // Seed 1 together with a word: history is the seed, not the prior state
      for (int i = 0; i < 3; i++) cycle("mix", 1, 1, 0, '0, rnd_word(), 0);
      cycle("seed1", 1, 1, 1, 58'h1, '0, 0);
      chk("seed1/vec", 64'(bus.Dat_o), 64'h0000000000800010);
      cycle("seed1n", 1, 1, 0, '0, rnd_word(), 0);

      // Seed load without a word, then scramble from it
      sd = {$urandom(), $urandom()};
      cycle("ldonly", 1, 0, 1, sd, rnd_word(), 0);
      for (int i = 0; i < 3; i++) cycle("postld", 1, 1, 0, '0, rnd_word(), 0);

      // Asynchronous reset between edges
      #3 Rs = 1'b1;
      #1;
      chk("arst/dat", 64'(bus.Dat_o), 64'h0);
      chk("arst/vld", 64'(bus.Vld_o), 64'h0);
      @(posedge Ck); #1;
      Rs = 1'b0;
      mdl_load(DI);
      exp_dat = '0;
      exp_vld = 1'b0;
      cycle("arst1", 1, 1, 0, '0, '0, 0);
      chk("arst1/vec", 64'(bus.Dat_o), 64'h00000000007FFFF0);

      // Random stream with gaps, descrambled loopback
      words = 0;
      while (words < 1000) begin
         ce = ($urandom_range(0, 9) != 0);
         en = ($urandom_range(0, 3) != 0);
         w  = rnd_word();
         cycle("rnd", ce, en, 0, '0, w, 0);
         if (ce && en) begin
            mdl_dscr(bus.Dat_o, rec);
            if (words >= 2) chk("loopback", 64'(rec), 64'(w));
            words++;
         end
      end

`ifdef SCRAM_PRBS_EN
      // PRBS mode: data ignored, descrambled stream is all zeros
      for (int i = 0; i < 20; i++) begin
         cycle("prbs", 1, 1, 0, '0, rnd_word(), 1);
         mdl_dscr(bus.Dat_o, rec);
         chk("prbs/ber", 64'(rec), 64'h0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
